// File: rtl/sequence_game_ctrl_if.sv
// Handshake bundle between the memory-game controller and its datapath/compare logic.
interface sequence_game_ctrl_if;
  logic       start;
  logic       cmp_valid;
  logic       cmp_match;
  logic       en_random_set;
  logic       en_random_load1;
  logic       en_store_random;
  logic       en_random_read;
  logic [3:0] colour_sel;
  logic [2:0] level;
  logic       busy;
  logic       await_input;
  logic       win;
  logic       lose;

  modport master (
    output start, cmp_valid, cmp_match,
    input  en_random_set, en_random_load1, en_store_random, en_random_read,
    input  colour_sel, level, busy, await_input, win, lose
  );

  modport slave (
    input  start, cmp_valid, cmp_match,
    output en_random_set, en_random_load1, en_store_random, en_random_read,
    output colour_sel, level, busy, await_input, win, lose
  );
endinterface

// File: rtl/sequence_game_ctrl.sv
// Moore controller for the colour-sequence memory game: seeds the LFSR, fills the
// sequence register, plays back `level` colours and tracks rounds 1..5 to win/lose.
module sequence_game_ctrl #(
  parameter int WARM_CYCLES   = 16,
  parameter int SHOW_CYCLES   = 25_000_000,
  parameter int GAP_CYCLES    = 5_000_000,
  parameter int INPUT_TIMEOUT = 250_000_000
) (
  input  logic                 clock,
  input  logic                 reset,
  sequence_game_ctrl_if.slave  bus
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int FILL_BITS = 15;
  localparam int CNT_MAX   = max2(max2(max2(WARM_CYCLES, SHOW_CYCLES),
                                       max2(GAP_CYCLES, INPUT_TIMEOUT)), FILL_BITS);
  localparam int CW        = $clog2(CNT_MAX + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t WARM_LAST = cnt_t'(WARM_CYCLES - 1);
  localparam cnt_t FILL_LAST = cnt_t'(FILL_BITS - 1);
  localparam cnt_t SHOW_LAST = cnt_t'(SHOW_CYCLES - 1);
  localparam cnt_t GAP_LAST  = cnt_t'(GAP_CYCLES - 1);
  localparam cnt_t TO_LAST   = cnt_t'(INPUT_TIMEOUT - 1);
  localparam cnt_t CNT_TOP   = cnt_t'(CNT_MAX);

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_SEED, S_WARM, S_FILL,
    S_SHOW, S_GAP, S_WAIT_IN, S_WIN, S_LOSE
  } state_t;

  state_t     state, state_n;
  cnt_t       cnt;
  logic [2:0] level, level_n;
  logic [2:0] k, k_n;
  logic       win_q, win_n, lose_q, lose_n;

  logic       o_set, o_load1, o_store, o_busy, o_await;
  logic [3:0] o_col;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      level  <= '0;
      k      <= '0;
      win_q  <= 1'b0;
      lose_q <= 1'b0;
    end else begin
      state  <= state_n;
      level  <= level_n;
      k      <= k_n;
      win_q  <= win_n;
      lose_q <= lose_n;
      // one shared counter: restarts on every state change, saturates otherwise
      if (state_n != state)  cnt <= '0;
      else if (cnt != CNT_TOP) cnt <= cnt + cnt_t'(1);
    end
  end

  always_comb begin
    state_n = state;
    level_n = level;
    k_n     = k;
    win_n   = win_q;
    lose_n  = lose_q;
    o_set   = 1'b1;
    o_load1 = 1'b0;
    o_store = 1'b0;
    o_busy  = 1'b1;
    o_await = 1'b0;
    o_col   = 4'd0;
    case (state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (bus.start) begin
          state_n = S_CLEAR;
          win_n   = 1'b0;
          lose_n  = 1'b0;
        end
      end
      S_CLEAR: begin
        o_set   = 1'b0;
        state_n = S_SEED;
      end
      S_SEED: begin
        o_load1 = 1'b1;
        state_n = S_WARM;
      end
      S_WARM: if (cnt == WARM_LAST) state_n = S_FILL;
      S_FILL: begin
        o_store = 1'b1;
        if (cnt == FILL_LAST) begin
          state_n = S_SHOW;
          level_n = 3'd1;
          k_n     = 3'd1;
        end
      end
      S_SHOW: begin
        o_col = {1'b0, k};
        if (cnt == SHOW_LAST) state_n = S_GAP;
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          k_n     = k + 3'd1;
          state_n = (k < level) ? S_SHOW : S_WAIT_IN;
        end
      end
      S_WAIT_IN: begin
        o_await = 1'b1;
        if (bus.cmp_valid) begin
          if (!bus.cmp_match)   state_n = S_LOSE;
          else if (level == 3'd5) state_n = S_WIN;
          else begin
            // k=0 so the increment at the end of the leading gap replays from colour 1
            level_n = level + 3'd1;
            k_n     = 3'd0;
            state_n = S_GAP;
          end
        end else if (cnt == TO_LAST) begin
          state_n = S_LOSE;
        end
      end
      S_WIN: begin
        win_n   = 1'b1;
        level_n = 3'd0;
        state_n = S_IDLE;
      end
      S_LOSE: begin
        lose_n  = 1'b1;
        level_n = 3'd0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign bus.en_random_set   = o_set;
  assign bus.en_random_load1 = o_load1;
  assign bus.en_store_random = o_store;
  assign bus.en_random_read  = 1'b0;
  assign bus.colour_sel      = o_col;
  assign bus.level           = level;
  assign bus.busy            = o_busy;
  assign bus.await_input     = o_await;
  assign bus.win             = win_q;
  assign bus.lose            = lose_q;

endmodule
